// File: rtl/matvec_pkg.sv
// Shared types and widths for the matrix-vector scheduler.
// Job fields are sized by the multiplier limits below, so those limits live here.
package matvec_pkg;

   localparam int NUM_REQ  = 4;
   localparam int MAX_ROWS = 64;
   localparam int MAX_COLS = 64;

   localparam int RW  = $clog2(MAX_ROWS);
   localparam int CW  = $clog2(MAX_COLS);
   localparam int AW  = $clog2(MAX_ROWS * MAX_COLS);
   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARB    = 3'd1,
      START  = 3'd2,
      VREQ   = 3'd3,
      VWRITE = 3'd4,
      RUN    = 3'd5,
      DONE   = 3'd6
   } sched_state_t;

   typedef struct packed {
      logic [RW-1:0]  rows;
      logic [CW-1:0]  cols;
      logic [AW-1:0]  mat_base;
      logic [IDW-1:0] id;
   } mv_job_t;

endpackage

// File: rtl/matvec_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping around.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW-1:0] j;

   // Walk offsets from farthest to nearest so the nearest set request is written last.
   always_comb begin
      j       = '0;
      grant_o = '0;
      idx_o   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = IW'((int'(ptr_i) + i) % N);
         if (req_i[j]) begin
            idx_o   = j;
            grant_o = N'(1) << j;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/matvec_scheduler.sv
// Shares one matvec multiplier among NUM_REQ requesters: round-robin grant,
// chunked vector load, registered result write-back and per-requester done.
module matvec_scheduler
   import matvec_pkg::*;
#(
   parameter int BANDWIDTH  = 16,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 4096
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*RW-1:0]           req_rows,
   input  logic [NUM_REQ*CW-1:0]           req_cols,
   input  logic [NUM_REQ*AW-1:0]           req_mat_base,
   output logic [NUM_REQ-1:0]              grant,
   output logic [NUM_REQ-1:0]              done,
   output logic                            error,
   output logic                            vec_rd_en,
   output logic [CW-1:0]                   vec_rd_addr,
   input  logic [BANDWIDTH*DATA_WIDTH-1:0] vec_rd_data,
   output logic [AW-1:0]                   mat_base,
   output logic                            mv_start,
   output logic [RW-1:0]                   mv_num_rows,
   output logic [CW-1:0]                   mv_num_cols,
   output logic                            mv_vec_we,
   output logic [CW-1:0]                   mv_vec_base,
   output logic [BANDWIDTH*DATA_WIDTH-1:0] mv_vec_data,
   input  logic [DATA_WIDTH-1:0]           mv_result,
   input  logic                            mv_result_valid,
   input  logic                            mv_busy,
   output logic                            res_wr_en,
   output logic [IDW-1:0]                  res_wr_id,
   output logic [RW-1:0]                   res_wr_addr,
   output logic [DATA_WIDTH-1:0]           res_wr_data,
   output logic [2:0]                      dbg_state
);

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [CW:0]   BW_STEP   = (CW + 1)'(BANDWIDTH);
   localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

   sched_state_t          state_q, state_d;
   mv_job_t               job_q, job_d;
   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [CW:0]           chunk_q, chunk_d;
   logic [RW:0]           row_cnt_q, row_cnt_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  err_q, err_d;
   logic                  res_en_q, res_en_d;
   logic [RW-1:0]         res_addr_q, res_addr_d;
   logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
   logic [IDW-1:0]        res_id_q, res_id_d;

   logic [NUM_REQ-1:0]    arb_grant;
   logic [IDW-1:0]        arb_idx;
   logic                  arb_any;
   logic [RW-1:0]         sel_rows;
   logic [CW-1:0]         sel_cols;
   logic [AW-1:0]         sel_base;
   logic [NUM_REQ-1:0]    id_onehot;

   rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .any_o   (arb_any)
   );

   assign sel_rows  = req_rows[arb_idx*RW +: RW];
   assign sel_cols  = req_cols[arb_idx*CW +: CW];
   assign sel_base  = req_mat_base[arb_idx*AW +: AW];
   assign id_onehot = NUM_REQ'(1) << job_q.id;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         job_q      <= '0;
         ptr_q      <= '0;
         chunk_q    <= '0;
         row_cnt_q  <= '0;
         timer_q    <= '0;
         err_q      <= 1'b0;
         res_en_q   <= 1'b0;
         res_addr_q <= '0;
         res_data_q <= '0;
         res_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         job_q      <= job_d;
         ptr_q      <= ptr_d;
         chunk_q    <= chunk_d;
         row_cnt_q  <= row_cnt_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
         res_en_q   <= res_en_d;
         res_addr_q <= res_addr_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      job_d       = job_q;
      ptr_d       = ptr_q;
      chunk_d     = chunk_q;
      row_cnt_d   = row_cnt_q;
      timer_d     = '0;
      err_d       = err_q;
      res_en_d    = 1'b0;
      res_addr_d  = res_addr_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      grant       = '0;
      done        = '0;
      error       = 1'b0;
      vec_rd_en   = 1'b0;
      mv_start    = 1'b0;
      mv_vec_we   = 1'b0;
      mv_vec_data = '0;

      case (state_q)
         IDLE: begin
            if (|req) state_d = ARB;
         end
         ARB: begin
            if (!arb_any) begin
               state_d = IDLE;
            end else begin
               grant = arb_grant;
               job_d = '{rows: sel_rows, cols: sel_cols, mat_base: sel_base, id: arb_idx};
               err_d = (sel_rows == '0) || (sel_cols == '0);
               state_d = ((sel_rows == '0) || (sel_cols == '0)) ? DONE : START;
            end
         end
         START: begin
            grant     = id_onehot;
            mv_start  = 1'b1;
            chunk_d   = '0;
            row_cnt_d = '0;
            state_d   = VREQ;
         end
         VREQ: begin
            grant     = id_onehot;
            vec_rd_en = 1'b1;
            state_d   = VWRITE;
         end
         VWRITE: begin
            grant       = id_onehot;
            mv_vec_we   = 1'b1;
            mv_vec_data = vec_rd_data;
            // One extra bit keeps chunk+BANDWIDTH from wrapping when cols is near MAX_COLS.
            if (chunk_q + BW_STEP >= {1'b0, job_q.cols}) begin
               state_d = RUN;
            end else begin
               chunk_d = chunk_q + BW_STEP;
               state_d = VREQ;
            end
         end
         RUN: begin
            grant   = id_onehot;
            timer_d = timer_q + TW'(1);
            if (mv_result_valid && (row_cnt_q < {1'b0, job_q.rows})) begin
               res_en_d   = 1'b1;
               res_addr_d = row_cnt_q[RW-1:0];
               res_data_d = mv_result;
               res_id_d   = job_q.id;
               row_cnt_d  = row_cnt_q + (RW + 1)'(1);
            end
            if ((row_cnt_q == {1'b0, job_q.rows}) && !mv_busy) begin
               state_d = DONE;
            end else if (timer_q >= TIMEOUT_V) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            grant   = id_onehot;
            done    = id_onehot;
            error   = err_q;
            ptr_d   = (job_q.id == IDW'(NUM_REQ - 1)) ? '0 : job_q.id + IDW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign vec_rd_addr = chunk_q[CW-1:0];
   assign mv_vec_base = chunk_q[CW-1:0];
   assign mat_base    = job_q.mat_base;
   assign mv_num_rows = job_q.rows;
   assign mv_num_cols = job_q.cols;
   assign res_wr_en   = res_en_q;
   assign res_wr_id   = res_id_q;
   assign res_wr_addr = res_addr_q;
   assign res_wr_data = res_data_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_matvec_scheduler.sv
// Directed bench for matvec_scheduler with a vector-source model and a stub multiplier
// that returns 16'h0A00+row per row, optionally extra results or none at all.
module tb_matvec_scheduler;
   import matvec_pkg::*;

   localparam int BW  = 16;
   localparam int DW  = 16;
   localparam int TMO = 4096;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*RW-1:0] req_rows;
   logic [NUM_REQ*CW-1:0] req_cols;
   logic [NUM_REQ*AW-1:0] req_mat_base;
   logic [NUM_REQ-1:0]    grant, done;
   logic                  error, vec_rd_en, mv_start, mv_vec_we, res_wr_en;
   logic [CW-1:0]         vec_rd_addr, mv_num_cols, mv_vec_base;
   logic [BW*DW-1:0]      vec_rd_data, mv_vec_data;
   logic [AW-1:0]         mat_base;
   logic [RW-1:0]         mv_num_rows, res_wr_addr;
   logic [DW-1:0]         mv_result, res_wr_data;
   logic                  mv_result_valid, mv_busy;
   logic [IDW-1:0]        res_wr_id;
   logic [2:0]            dbg_state;

   always #5 clk = ~clk;

   matvec_scheduler #(.BANDWIDTH(BW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_rows(req_rows), .req_cols(req_cols),
      .req_mat_base(req_mat_base), .grant(grant), .done(done), .error(error),
      .vec_rd_en(vec_rd_en), .vec_rd_addr(vec_rd_addr), .vec_rd_data(vec_rd_data),
      .mat_base(mat_base), .mv_start(mv_start), .mv_num_rows(mv_num_rows),
      .mv_num_cols(mv_num_cols), .mv_vec_we(mv_vec_we), .mv_vec_base(mv_vec_base),
      .mv_vec_data(mv_vec_data), .mv_result(mv_result), .mv_result_valid(mv_result_valid),
      .mv_busy(mv_busy), .res_wr_en(res_wr_en), .res_wr_id(res_wr_id),
      .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data), .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [BW*DW-1:0] obs, input logic [BW*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW*DW-1:0] pattern(input logic [CW-1:0] base);
      logic [BW*DW-1:0] v;
      v = '0;
      for (int e = 0; e < BW; e++) v[e*DW +: DW] = {2'b00, base, 8'(e)};
      return v;
   endfunction

   // Vector source: data is present during the cycle after the read strobe.
   initial begin
      vec_rd_data = '0;
      forever begin
         @(negedge clk);
         if (vec_rd_en) vec_rd_data = pattern(vec_rd_addr);
      end
   end

   // Stub multiplier.
   int stub_extra = 0;
   bit stub_dead  = 1'b0;
   initial begin
      mv_busy = 1'b0; mv_result_valid = 1'b0; mv_result = '0;
      forever begin
         @(negedge clk);
         if (mv_start && !rst) begin
            int n;
            int k;
            n = int'(mv_num_rows) + stub_extra;
            mv_busy = 1'b1;
            k = 0;
            while (!rst && !(mv_vec_we && (int'(mv_vec_base) + BW >= int'(mv_num_cols))) && k < 200) begin
               @(negedge clk);
               k++;
            end
            if (stub_dead) begin
               k = 0;
               while (!rst && done == '0 && k < TMO + 200) begin
                  @(negedge clk);
                  k++;
               end
            end else begin
               for (int r = 0; r < n && !rst; r++) begin
                  @(negedge clk);
                  mv_result_valid = 1'b1;
                  mv_result = 16'(16'h0A00 + r);
                  @(negedge clk);
                  mv_result_valid = 1'b0;
               end
            end
            mv_busy = 1'b0;
         end
      end
   end

   // Scoreboard capture of DUT traffic.
   logic [CW-1:0]      rd_q[$];
   logic [CW-1:0]      we_q[$];
   logic [BW*DW-1:0]   wd_q[$];
   logic [23:0]        res_q[$];
   logic [4:0]         done_q[$];
   int                 start_cnt = 0;
   logic [NUM_REQ-1:0] start_grant = '0;
   always @(negedge clk) begin
      if (vec_rd_en) rd_q.push_back(vec_rd_addr);
      if (mv_vec_we) begin
         we_q.push_back(mv_vec_base);
         wd_q.push_back(mv_vec_data);
      end
      if (res_wr_en) res_q.push_back({res_wr_id, res_wr_addr, res_wr_data});
      if (done != '0) done_q.push_back({done, error});
      if (mv_start) begin
         start_cnt++;
         start_grant = grant;
      end
   end

   task automatic clear_sb();
      rd_q.delete(); we_q.delete(); wd_q.delete(); res_q.delete(); done_q.delete();
      start_cnt = 0;
   endtask

   task automatic set_job(input int id, input int rows, input int cols, input int base);
      req_rows[id*RW +: RW]     = RW'(rows);
      req_cols[id*CW +: CW]     = CW'(cols);
      req_mat_base[id*AW +: AW] = AW'(base);
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (done == '0 && cycles < 6000) begin
         @(negedge clk);
         cycles++;
      end
      check("done_seen", {255'd0, (done != '0)}, 1);
   endtask

   task automatic check_results(input string tag, input int id, input int rows);
      check({tag, "_res_count"}, res_q.size(), rows);
      for (int i = 0; i < rows && i < res_q.size(); i++)
         check({tag, "_res"}, res_q[i], {2'(id), 6'(i), 16'(16'h0A00 + i)});
   endtask

   initial begin
      int cyc;
      logic [3:0] exp_order [5];
      exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
      exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

      rst = 1'b1; req = '0; req_rows = '0; req_cols = '0; req_mat_base = '0;
      repeat (3) @(negedge clk);
      check("rst_state", dbg_state, 3'd0);
      check("rst_ctrl", {grant, done, error, vec_rd_en, mv_start, mv_vec_we, res_wr_en}, 0);
      check("rst_data", {vec_rd_addr, mv_vec_base, mat_base, mv_num_rows, mv_num_cols,
                         res_wr_addr, res_wr_data, res_wr_id}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single chunk, four rows.
      clear_sb();
      set_job(0, 4, 16, 12'h040);
      req = 4'b0001;
      wait_done(cyc);
      check("t1_done", done, 4'b0001);
      check("t1_error", error, 0);
      req = 4'b0000;
      @(negedge clk);
      check("t1_starts", start_cnt, 1);
      check("t1_grant_mid", start_grant, 4'b0001);
      check("t1_rd_count", rd_q.size(), 1);
      if (rd_q.size() > 0) check("t1_rd_addr", rd_q[0], 0);
      if (wd_q.size() > 0) check("t1_vec_data", wd_q[0], pattern(6'd0));
      check_results("t1", 0, 4);
      check("t1_grant_idle", grant, 0);

      // Three chunks, extra results from the multiplier must be dropped.
      clear_sb();
      stub_extra = 2;
      set_job(1, 3, 40, 12'h123);
      req = 4'b0010;
      wait_done(cyc);
      check("t2_done", done, 4'b0010);
      check("t2_error", error, 0);
      check("t2_mat_base", mat_base, 12'h123);
      check("t2_num_cols", mv_num_cols, 40);
      req = 4'b0000;
      @(negedge clk);
      stub_extra = 0;
      check("t2_rd_count", rd_q.size(), 3);
      check("t2_we_count", we_q.size(), 3);
      for (int i = 0; i < 3 && i < rd_q.size() && i < we_q.size(); i++) begin
         check("t2_rd_addr", rd_q[i], 16 * i);
         check("t2_we_base", we_q[i], 16 * i);
         check("t2_vec_data", wd_q[i], pattern(6'(16 * i)));
      end
      check_results("t2", 1, 3);

      // Zero rows: rejected, done on the third cycle counting the request cycle.
      clear_sb();
      set_job(2, 0, 16, 12'h000);
      req = 4'b0100;
      wait_done(cyc);
      check("t4_latency", cyc, 2);
      check("t4_done", done, 4'b0100);
      check("t4_error", error, 1);
      req = 4'b0000;
      @(negedge clk);
      check("t4_no_start", start_cnt, 0);

      // Multiplier never answers: timeout abort.
      clear_sb();
      stub_dead = 1'b1;
      set_job(3, 4, 16, 12'h010);
      req = 4'b1000;
      cyc = 0;
      while (!mv_start && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("t5_start_seen", mv_start, 1);
      wait_done(cyc);
      check("t5_timeout_cycles", cyc, TMO + 4);
      check("t5_done", done, 4'b1000);
      check("t5_error", error, 1);
      req = 4'b0000;
      @(negedge clk);
      stub_dead = 1'b0;
      check("t5_no_writes", res_q.size(), 0);

      // All four requesting continuously: pointer is at 0 now.
      clear_sb();
      for (int i = 0; i < NUM_REQ; i++) set_job(i, 2, 16, 64 * i);
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         wait_done(cyc);
         check("t3_order", done, exp_order[j]);
         if (j == 4) req = 4'b0000;
         @(negedge clk);
      end
      check("t3_res_count", res_q.size(), 10);

      // Reset in the middle of a vector write, then a clean job.
      clear_sb();
      set_job(0, 4, 40, 12'h200);
      req = 4'b0001;
      cyc = 0;
      while (!mv_vec_we && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("t6_vwrite_seen", mv_vec_we, 1);
      rst = 1'b1;
      req = 4'b0000;
      @(negedge clk);
      check("t6_rst_state", dbg_state, 3'd0);
      check("t6_rst_ctrl", {grant, done, error, vec_rd_en, mv_start, mv_vec_we, res_wr_en}, 0);
      check("t6_rst_data", {vec_rd_addr, mv_vec_base, mat_base, mv_num_rows, mv_num_cols}, 0);
      check("t6_rst_vec", mv_vec_data, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_no_done", done_q.size(), 0);
      clear_sb();
      set_job(3, 2, 16, 12'h300);
      req = 4'b1000;
      wait_done(cyc);
      check("t6_done", done, 4'b1000);
      check("t6_error", error, 0);
      req = 4'b0000;
      @(negedge clk);
      check("t6_grant_mid", start_grant, 4'b1000);
      check_results("t6", 3, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
